// File: rtl/spi_pkg.sv
// Shared types and default sizes for the SPI responder.
// Imported by the responder top level.
package spi_pkg;

    typedef enum logic {
        IDLE,
        ACTIVE
    } spi_state_t;

    localparam int SPI_WORD_BITS   = 16;
    localparam int SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser with rise/fall detect on the synchronised level.
// Edges are suppressed until the history holds only post-reset samples.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              hist;
    logic [STAGES:0]   seen;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chain <= {STAGES{RST_VAL}};
            hist  <= RST_VAL;
            seen  <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            hist  <= chain[STAGES-1];
            seen  <= {seen[STAGES-1:0], 1'b1};
        end
    end

    // A level held through reset must not look like an edge afterwards
    assign rise = seen[STAGES] & chain[STAGES-1] & ~hist;
    assign fall = seen[STAGES] & ~chain[STAGES-1] & hist;

endmodule

// File: rtl/spi_responder.sv
// Mode-0 SPI responder: oversampled pins, rx word stream out, tx word stream in.
// Multi-word frames are continuous; cs_n rise ends the frame.
module spi_responder
    import spi_pkg::*;
#(
    parameter int                   WORD_BITS   = SPI_WORD_BITS,
    parameter int                   SYNC_STAGES = SPI_SYNC_STAGES,
    parameter logic [WORD_BITS-1:0] DEFAULT_TX  = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sclk,
    input  logic                 cs_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [WORD_BITS-1:0] rx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [WORD_BITS-1:0] tx_data,
    output logic                 frame_error,
    output logic                 rx_overflow,
    output logic                 tx_underrun
);

    localparam int CW = $clog2(WORD_BITS);
    localparam logic [CW-1:0] LAST = CW'(WORD_BITS - 1);

    spi_state_t           state;
    logic [CW-1:0]        bit_cnt;
    logic [WORD_BITS-1:0] rx_shift;
    logic [WORD_BITS-1:0] tx_shift;
    logic [SYNC_STAGES-1:0] mosi_sync;

    logic                 sclk_rise;
    logic                 sclk_fall;
    logic                 cs_rise;
    logic                 cs_fall;
    logic                 mosi_s;
    logic                 tx_load;
    logic                 word_done;
    logic [WORD_BITS-1:0] load_word;
    logic [WORD_BITS-1:0] rx_word;

    sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sclk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (sclk),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_cs_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (cs_n),
        .rise    (cs_rise),
        .fall    (cs_fall)
    );

    // Same depth as the sclk chain so mosi lines up with the detected edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mosi_sync <= '0;
        end else begin
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    always_comb begin
        load_word = tx_valid ? tx_data : DEFAULT_TX;
        rx_word   = {rx_shift[WORD_BITS-2:0], mosi_s};
        word_done = (state == ACTIVE) && !cs_rise
                    && sclk_rise && (bit_cnt == LAST);
        tx_load   = reset_n
                    && (((state == IDLE) && cs_fall)
                        || ((state == ACTIVE) && !cs_rise
                            && sclk_fall && (bit_cnt == '0)));
    end

    assign tx_ready = tx_load;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            miso        <= 1'b0;
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            frame_error <= 1'b0;
            rx_overflow <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            rx_overflow <= 1'b0;
            tx_underrun <= tx_load && !tx_valid;

            if (word_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= rx_word;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overflow <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state    <= ACTIVE;
                        bit_cnt  <= '0;
                        tx_shift <= load_word;
                        miso     <= load_word[WORD_BITS-1];
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state       <= IDLE;
                        bit_cnt     <= '0;
                        rx_shift    <= '0;
                        miso        <= 1'b0;
                        frame_error <= (bit_cnt != '0);
                    end else begin
                        if (sclk_rise) begin
                            rx_shift <= rx_word;
                            bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
                        end
                        // A zero count on the falling edge means a word boundary
                        if (sclk_fall) begin
                            if (bit_cnt == '0) begin
                                tx_shift <= load_word;
                                miso     <= load_word[WORD_BITS-1];
                            end else begin
                                tx_shift <= {tx_shift[WORD_BITS-2:0], 1'b0};
                                miso     <= tx_shift[WORD_BITS-2];
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_responder.sv
// Scoreboard bench for spi_responder: a mode-0 master model drives frames,
// a negedge monitor pops expected rx words and counts status pulses.
module tb_spi_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic        rx_valid;
    logic        rx_ready = 1'b1;
    logic [15:0] rx_data;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [15:0] tx_data = 16'h0;
    logic        frame_error;
    logic        rx_overflow;
    logic        tx_underrun;

    int errors = 0;
    int checks = 0;
    int n_txr = 0, n_und = 0, n_ovf = 0, n_ferr = 0, n_rx = 0, n_mhi = 0;
    int b_txr, b_und, b_ovf, b_ferr, b_rx, b_mhi;

    logic [15:0] exp_rx[$];
    logic [15:0] exp_miso[$];
    logic [15:0] tx_q[$];
    logic [15:0] mosi_q[$];

    spi_responder dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .miso        (miso),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .frame_error (frame_error),
        .rx_overflow (rx_overflow),
        .tx_underrun (tx_underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (tx_ready) n_txr++;
            if (tx_underrun) n_und++;
            if (rx_overflow) n_ovf++;
            if (frame_error) n_ferr++;
            if (miso) n_mhi++;
            if (rx_valid && rx_ready) begin
                n_rx++;
                if (exp_rx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got %0h want none", rx_data);
                end else begin
                    check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (tx_valid && tx_ready) begin
                @(posedge clk);
                #1;
                void'(tx_q.pop_front());
            end
            tx_valid = (tx_q.size() != 0);
            tx_data  = tx_valid ? tx_q[0] : 16'h0;
        end
    end

    task automatic snap();
        b_txr = n_txr; b_und = n_und; b_ovf = n_ovf;
        b_ferr = n_ferr; b_rx = n_rx; b_mhi = n_mhi;
    endtask

    // Final sclk fall coincides with cs_n rise, as a mode-0 master ends a frame
    task automatic frame(input int last_bits);
        int nw;
        logic [15:0] d;
        logic [15:0] got;
        int nb;
        nw = mosi_q.size();
        cs_n = 1'b0;
        #50;
        for (int w = 0; w < nw; w++) begin
            d = mosi_q[w];
            got = 16'h0;
            nb = (w == nw - 1) ? last_bits : 16;
            for (int b = 0; b < nb; b++) begin
                mosi = d[15-b];
                #50 sclk = 1'b1;
                got = {got[14:0], miso};
                #50 sclk = 1'b0;
                if (w == nw - 1 && b == nb - 1) cs_n = 1'b1;
            end
            if (nb == 16 && exp_miso.size() != 0)
                check("miso_word", 32'(got), 32'(exp_miso.pop_front()));
        end
        mosi_q.delete();
        #200;
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check("rst_miso", 32'(miso), 0);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_rx_data", 32'(rx_data), 0);
        check("rst_tx_ready", 32'(tx_ready), 0);
        check("rst_pulses", 32'({frame_error, rx_overflow, tx_underrun}), 0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // single word
        snap();
        tx_q.push_back(16'h1234);
        exp_miso.push_back(16'h1234);
        mosi_q.push_back(16'hA5C3);
        exp_rx.push_back(16'hA5C3);
        #100;
        frame(16);
        check("t1_tx_ready", n_txr - b_txr, 1);
        check("t1_underrun", n_und - b_und, 0);
        check("t1_rx_count", n_rx - b_rx, 1);
        check("t1_rx_drain", exp_rx.size(), 0);

        // three-word frame with underrun
        snap();
        tx_q.push_back(16'hBEEF);
        exp_miso.push_back(16'hBEEF);
        exp_miso.push_back(16'h0000);
        exp_miso.push_back(16'h0000);
        for (int i = 1; i <= 3; i++) begin
            mosi_q.push_back(16'(i));
            exp_rx.push_back(16'(i));
        end
        #100;
        frame(16);
        check("t2_underrun", n_und - b_und, 2);
        check("t2_tx_ready", n_txr - b_txr, 3);
        check("t2_rx_count", n_rx - b_rx, 3);
        check("t2_rx_drain", exp_rx.size(), 0);

        // overflow while holding register full
        snap();
        @(posedge clk);
        #1 rx_ready = 1'b0;
        mosi_q.push_back(16'h1111);
        mosi_q.push_back(16'h2222);
        frame(16);
        check("t3_rx_valid", 32'(rx_valid), 1);
        check("t3_rx_data", 32'(rx_data), 32'h1111);
        check("t3_overflow", n_ovf - b_ovf, 1);
        exp_rx.push_back(16'h1111);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("t3_rx_valid_after", 32'(rx_valid), 0);
        check("t3_rx_drain", exp_rx.size(), 0);

        // aborted frame then a good one
        snap();
        mosi_q.push_back(16'hFFFF);
        frame(7);
        check("t4_frame_error", n_ferr - b_ferr, 1);
        check("t4_no_rx", n_rx - b_rx, 0);
        mosi_q.push_back(16'h00FF);
        exp_rx.push_back(16'h00FF);
        frame(16);
        check("t4_rx_drain", exp_rx.size(), 0);

        // reset mid-word with cs_n held low
        cs_n = 1'b0;
        #50;
        for (int b = 0; b < 5; b++) begin
            mosi = 1'b1;
            #50 sclk = 1'b1;
            #50 sclk = 1'b0;
        end
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_rst_miso", 32'(miso), 0);
        check("t5_rst_rx_valid", 32'(rx_valid), 0);
        reset_n = 1'b1;
        snap();
        for (int b = 0; b < 27; b++) begin
            mosi = b[0];
            #50 sclk = 1'b1;
            #50 sclk = 1'b0;
        end
        #200;
        check("t5_miso_low", n_mhi - b_mhi, 0);
        check("t5_no_rx", n_rx - b_rx, 0);
        check("t5_no_tx_ready", n_txr - b_txr, 0);
        cs_n = 1'b1;
        #200;
        mosi_q.push_back(16'h5A5A);
        exp_rx.push_back(16'h5A5A);
        frame(16);
        check("t5_rx_count", n_rx - b_rx, 1);
        check("t5_rx_drain", exp_rx.size(), 0);

        // sclk activity with cs_n high
        snap();
        for (int b = 0; b < 20; b++) begin
            mosi = ~b[1];
            #50 sclk = 1'b1;
            #50 sclk = 1'b0;
        end
        #200;
        check("t6_no_rx", n_rx - b_rx, 0);
        check("t6_no_tx_ready", n_txr - b_txr, 0);
        check("t6_miso_low", n_mhi - b_mhi, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
